// File: rtl/ram_bridge_pkg.sv
// Shared definitions for the 32-bit word to 8-bit ram bridge.
// Holds the FSM state encoding and the number of byte beats per word.
// Imported by ram_word_bridge.
package ram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int BEATS = 4;

endpackage

// File: rtl/ram_word_bridge.sv
// Bridges single 32-bit word accesses onto an 8-bit async-read ram, one byte per cycle.
// Latency: request at edge N -> 4 ACCESS cycles -> bus_ready in the cycle after edge N+4.
// Backpressure: requests are sampled only in IDLE; bus_req while busy is dropped, never queued.
module ram_word_bridge
  import ram_bridge_pkg::*;
#(
  parameter int ADDR_BITS = 10  // byte address width of the ram, at least 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_req,
  input  logic                 bus_we,
  input  logic [ADDR_BITS-1:0] bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_be,
  output logic                 bus_busy,
  output logic                 bus_ready,
  output logic [31:0]          bus_rdata,
  output logic                 ram_ena,
  output logic                 ram_wena,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [7:0]           ram_din,
  input  logic [7:0]           ram_dout
);

  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             beat;
  logic                   lat_we;
  logic [ADDR_BITS-3:0]   lat_waddr;
  logic [31:0]            lat_wdata;
  logic [3:0]             lat_be;
  logic [31:0]            rbuf;
  logic [31:0]            rdata;
  logic                   last_beat;
  logic                   unused_addr_lsbs;

  // The low two address bits are ignored: accesses are always word-aligned.
  assign unused_addr_lsbs = ^bus_addr[1:0];

  assign last_beat = (beat == 2'(BEATS - 1));
  assign bus_rdata = rdata;

  // Next-state and ram/bus strobes; everything is zero outside ACCESS/DONE.
  always_comb begin
    state_nxt = state;
    bus_busy  = 1'b0;
    bus_ready = 1'b0;
    ram_ena   = 1'b0;
    ram_wena  = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      IDLE: begin
        if (bus_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus_busy = 1'b1;
        ram_ena  = 1'b1;
        // Beat only drives the two low bits, so the top word never wraps to 0.
        ram_addr = {lat_waddr, beat};
        ram_din  = lat_wdata[{beat, 3'b000} +: 8];
        ram_wena = lat_we & lat_be[beat];
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        bus_busy  = 1'b1;
        bus_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latch, beat counter and read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      lat_we    <= 1'b0;
      lat_waddr <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rbuf      <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus_req) begin
            lat_we    <= bus_we;
            lat_waddr <= bus_addr[ADDR_BITS-1:2];
            lat_wdata <= bus_wdata;
            lat_be    <= bus_be;
            beat      <= '0;
          end
        end
        ACCESS: begin
          beat <= beat + 2'd1;
          if (!lat_we) begin
            rbuf[{beat, 3'b000} +: 8] <= ram_dout;
            // Publish the whole word at once on entry to DONE; the last byte
            // comes straight from the ram since rbuf is not yet updated.
            if (last_beat) rdata <= {ram_dout, rbuf[23:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_word_bridge.sv
// Directed self-checking bench for ram_word_bridge with a 1 KiB async-read ram model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Each comparison is an immediate assertion feeding the summary counters.
module tb_ram_word_bridge;

  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_req;
  logic          bus_we;
  logic [AB-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_busy;
  logic          bus_ready;
  logic [31:0]   bus_rdata;
  logic          ram_ena;
  logic          ram_wena;
  logic [AB-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;

  logic [7:0] mem [0:(1<<AB)-1] = '{default: 8'h00};

  int checks   = 0;
  int failures = 0;

  // Per-transaction logs, index k = sample taken after edge N+k.
  logic [AB-1:0] alog [16];
  logic [31:0]   dlog [16];
  logic [15:0]   rdy_vec;
  int            wcnt;
  logic          bad_wena;

  always #5 clk = ~clk;

  // Ram model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  ram_word_bridge #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_busy  (bus_busy),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .ram_ena   (ram_ena),
    .ram_wena  (ram_wena),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // Issue one request (req held for 'hold' edges) and log ncyc cycles after acceptance.
  task automatic run(input logic we, input logic [AB-1:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, input int ncyc);
    bus_we    = we;
    bus_addr  = a;
    bus_wdata = wd;
    bus_be    = be;
    bus_req   = 1'b1;
    rdy_vec   = '0;
    wcnt      = 0;
    bad_wena  = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      if (k + 1 >= hold) bus_req = 1'b0;
      alog[k]    = ram_addr;
      dlog[k]    = bus_rdata;
      rdy_vec[k] = bus_ready;
      if (ram_wena) wcnt++;
      if (ram_wena && !ram_ena) bad_wena = 1'b1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    step();
    step();

    // Reset state
    chk("rst_busy",  {31'd0, bus_busy},  32'd0);
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_ram",   {20'd0, ram_ena, ram_wena, ram_addr}, 32'd0);
    chk("rst_din",   {24'd0, ram_din}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rst = 1'b0;
    step();

    // Full write of DEADBEEF to 0x010
    run(1'b1, 10'h010, 32'hDEADBEEF, 4'b1111, 1, 8);
    chk("wr1_ready_vec", {16'd0, rdy_vec}, 32'h0000_0010);
    chk("wr1_mem",       mem_word(10'h010), 32'hDEADBEEF);
    chk("wr1_wcnt",      wcnt, 32'd4);
    chk("wr1_wena_ena",  {31'd0, bad_wena}, 32'd0);
    chk("wr1_rdata",     bus_rdata, 32'd0);

    // Read from 0x012 (word 0x010)
    run(1'b0, 10'h012, 32'h0, 4'b0000, 1, 8);
    chk("rd1_addr0", {22'd0, alog[0]}, 32'h010);
    chk("rd1_addr1", {22'd0, alog[1]}, 32'h011);
    chk("rd1_addr2", {22'd0, alog[2]}, 32'h012);
    chk("rd1_addr3", {22'd0, alog[3]}, 32'h013);
    chk("rd1_no_partial", dlog[3], 32'd0);
    chk("rd1_rdata",  dlog[4], 32'hDEADBEEF);
    chk("rd1_ready_vec", {16'd0, rdy_vec}, 32'h0000_0010);
    chk("rd1_wcnt",   wcnt, 32'd0);

    // Partial write be=0101 then read back
    run(1'b1, 10'h010, 32'h11223344, 4'b0101, 1, 8);
    chk("wr2_wcnt",  wcnt, 32'd2);
    chk("wr2_rdata_held", bus_rdata, 32'hDEADBEEF);
    run(1'b0, 10'h010, 32'h0, 4'b1111, 1, 8);
    chk("rd2_rdata", dlog[4], 32'hDE22BE44);

    // Write with no byte enables: four beats, no ram writes, still a ready pulse
    run(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, 1, 8);
    chk("wr0_ready_vec", {16'd0, rdy_vec}, 32'h0000_0010);
    chk("wr0_wcnt", wcnt, 32'd0);
    chk("wr0_mem",  mem_word(10'h010), 32'hDE22BE44);

    // bus_req held high: back-to-back reads, ready 6 cycles apart
    run(1'b0, 10'h010, 32'h0, 4'b0000, 8, 16);
    chk("b2b_ready_vec", {16'd0, rdy_vec}, 32'h0000_0410);
    chk("b2b_rdata", dlog[10], 32'hDE22BE44);

    // Reset in the middle of a write to 0x020
    run(1'b1, 10'h020, 32'h0, 4'b1111, 1, 8);
    bus_we    = 1'b1;
    bus_addr  = 10'h020;
    bus_wdata = 32'hAABBCCDD;
    bus_be    = 4'b1111;
    bus_req   = 1'b1;
    step();
    bus_req = 1'b0;
    chk("abort_beat0", {20'd0, ram_ena, ram_wena, ram_addr}, {20'd0, 2'b11, 10'h020});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs", {bus_busy, bus_ready, ram_ena, ram_wena, ram_din, ram_addr},
        32'd0);
    chk("abort_rdata", bus_rdata, 32'd0);
    rdy_vec = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      rdy_vec[k] = bus_ready | bus_busy;
    end
    chk("abort_quiet", {16'd0, rdy_vec}, 32'd0);
    chk("abort_mem", mem_word(10'h020), 32'h000000DD);

    // Top word: write then read 0x3FC, beats must not wrap to 0x000
    run(1'b1, 10'h3FC, 32'h04030201, 4'b1111, 1, 8);
    chk("top_wr_mem", mem_word(10'h3FC), 32'h04030201);
    chk("top_mem0",   {24'd0, mem[0]}, 32'd0);
    run(1'b0, 10'h3FC, 32'h0, 4'b0000, 1, 8);
    chk("top_addr0", {22'd0, alog[0]}, 32'h3FC);
    chk("top_addr3", {22'd0, alog[3]}, 32'h3FF);
    chk("top_addr4", {22'd0, alog[4]}, 32'h000);
    chk("top_rdata", dlog[4], 32'h04030201);

    // rst wins over bus_req on the same edge
    rst     = 1'b1;
    bus_req = 1'b1;
    bus_we  = 1'b0;
    step();
    chk("rst_prio_busy", {31'd0, bus_busy}, 32'd0);
    chk("rst_prio_ena",  {31'd0, ram_ena},  32'd0);
    chk("rst_prio_rdata", bus_rdata, 32'd0);
    rst     = 1'b0;
    bus_req = 1'b0;
    step();
    chk("rst_prio_idle", {31'd0, bus_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
